// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: owns the intro/menu/play/pause/over/restart flow of the snake
// game and generates the difficulty-dependent move tick. All outputs are registered.
module game_flow_sequencer #(
    parameter int unsigned INTRO_CYCLES = 32'd130_000_000,
    parameter int unsigned DIV_0        = 32'd13_000_000,
    parameter int unsigned DIV_1        = 32'd8_125_000,
    parameter int unsigned DIV_2        = 32'd4_875_000,
    parameter int unsigned DIV_3        = 32'd3_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       key_valid,
    input  logic       game_over,
    input  logic [1:0] difficulty_level,
    output logic       game_start,
    output logic       menu_interrupt,
    output logic       game_restart,
    output logic       move_tick,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        ST_INTRO   = 3'd0,
        ST_MENU    = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_OVER    = 3'd4,
        ST_RESTART = 3'd5
    } state_e;

    localparam logic [7:0]  KEY_ENTER  = 8'h0D;
    localparam logic [7:0]  KEY_PAUSE  = 8'h70;
    localparam logic [7:0]  KEY_MENU   = 8'h6D;
    localparam logic [7:0]  KEY_RETRY  = 8'h72;
    localparam logic [31:0] INTRO_LAST = 32'(INTRO_CYCLES - 32'd1);

    logic [2:0]  state_q, state_d;
    logic [31:0] intro_cnt_q, intro_cnt_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]  div_sel_q, div_sel_d;
    logic        tick_d;
    logic [31:0] div_last_s;
    logic        key_enter_s, key_p_s, key_m_s, key_r_s;
    logic        game_start_q, menu_interrupt_q, game_restart_q, move_tick_q;
    logic [2:0]  state_dbg_q;

    assign key_enter_s = key_valid && (key == KEY_ENTER);
    assign key_p_s     = key_valid && (key == KEY_PAUSE);
    assign key_m_s     = key_valid && (key == KEY_MENU);
    assign key_r_s     = key_valid && (key == KEY_RETRY);

    // Terminal count of the tick counter for the latched difficulty
    always_comb begin
        div_last_s = 32'(DIV_0 - 32'd1);
        case (div_sel_q)
            2'd0:    div_last_s = 32'(DIV_0 - 32'd1);
            2'd1:    div_last_s = 32'(DIV_1 - 32'd1);
            2'd2:    div_last_s = 32'(DIV_2 - 32'd1);
            2'd3:    div_last_s = 32'(DIV_3 - 32'd1);
            default: div_last_s = 32'(DIV_0 - 32'd1);
        endcase
    end

    // Next-state, counter and tick computation
    always_comb begin
        state_d     = state_q;
        intro_cnt_d = intro_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        div_sel_d   = div_sel_q;
        tick_d      = 1'b0;
        case (state_q)
            ST_INTRO: begin
                if (key_valid || (intro_cnt_q == INTRO_LAST)) begin
                    state_d     = ST_MENU;
                    intro_cnt_d = 32'd0;
                end else begin
                    intro_cnt_d = intro_cnt_q + 32'd1;
                end
            end
            ST_MENU: begin
                if (key_enter_s) begin
                    state_d    = ST_PLAY;
                    div_sel_d  = difficulty_level;
                    tick_cnt_d = 32'd0;
                end else begin
                    state_d = ST_MENU;
                end
            end
            ST_PLAY: begin
                // A leaving cycle neither counts nor ticks, so pause length adds exactly
                if (game_over) begin
                    state_d = ST_OVER;
                end else if (key_p_s) begin
                    state_d = ST_PAUSE;
                end else if (key_m_s) begin
                    state_d = ST_MENU;
                end else if (tick_cnt_q == div_last_s) begin
                    tick_d     = 1'b1;
                    tick_cnt_d = 32'd0;
                end else begin
                    tick_cnt_d = tick_cnt_q + 32'd1;
                end
            end
            ST_PAUSE: begin
                if (key_p_s) begin
                    state_d = ST_PLAY;
                end else if (key_m_s) begin
                    state_d = ST_MENU;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (key_r_s) begin
                    state_d = ST_RESTART;
                end else if (key_enter_s) begin
                    state_d = ST_MENU;
                end else begin
                    state_d = ST_OVER;
                end
            end
            ST_RESTART: begin
                if (!game_over) begin
                    state_d    = ST_PLAY;
                    tick_cnt_d = 32'd0;
                end else begin
                    state_d = ST_RESTART;
                end
            end
            default: begin
                state_d     = ST_INTRO;
                intro_cnt_d = 32'd0;
                tick_cnt_d  = 32'd0;
            end
        endcase
    end

    // State, counters and registered outputs (outputs derived from the next state)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_INTRO;
            intro_cnt_q      <= 32'd0;
            tick_cnt_q       <= 32'd0;
            div_sel_q        <= 2'd0;
            game_start_q     <= 1'b0;
            menu_interrupt_q <= 1'b0;
            game_restart_q   <= 1'b0;
            move_tick_q      <= 1'b0;
            state_dbg_q      <= 3'd0;
        end else begin
            state_q          <= state_d;
            intro_cnt_q      <= intro_cnt_d;
            tick_cnt_q       <= tick_cnt_d;
            div_sel_q        <= div_sel_d;
            game_start_q     <= (state_d != ST_INTRO);
            menu_interrupt_q <= (state_d == ST_MENU) || (state_d == ST_PAUSE);
            game_restart_q   <= (state_d == ST_RESTART);
            move_tick_q      <= tick_d;
            state_dbg_q      <= state_d;
        end
    end

    assign game_start     = game_start_q;
    assign menu_interrupt = menu_interrupt_q;
    assign game_restart   = game_restart_q;
    assign move_tick      = move_tick_q;
    assign state_dbg      = state_dbg_q;
endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed self-checking bench for game_flow_sequencer with small intro/divider values.
module tb_game_flow_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key;
    logic       key_valid;
    logic       game_over;
    logic [1:0] difficulty_level;
    logic       game_start, menu_interrupt, game_restart, move_tick;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    game_flow_sequencer #(
        .INTRO_CYCLES(32'd10),
        .DIV_0(32'd7),
        .DIV_1(32'd6),
        .DIV_2(32'd5),
        .DIV_3(32'd4)
    ) dut (
        .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
        .game_over(game_over), .difficulty_level(difficulty_level),
        .game_start(game_start), .menu_interrupt(menu_interrupt),
        .game_restart(game_restart), .move_tick(move_tick), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Present a key for one edge; returns on the following negedge
    task automatic send_key(input logic [7:0] k);
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({game_start, menu_interrupt, game_restart, move_tick, state_dbg} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {game_start, menu_interrupt, game_restart, move_tick, state_dbg});
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (game_start !== (i == 10)) begin
                failures++;
                $display("FAIL intro_timeout cycle %0d: game_start=%b expected %b", i, game_start, (i == 10));
            end
        end
        checks++;
        if (state_dbg !== 3'd1 || menu_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL intro_to_menu: state=%0d mi=%b expected 1/1", state_dbg, menu_interrupt);
        end
    endtask

    task automatic test_play_ticks();
        difficulty_level = 2'd2;
        send_key(8'h0D);
        checks++;
        if (state_dbg !== 3'd2 || menu_interrupt !== 1'b0 || move_tick !== 1'b0) begin
            failures++;
            $display("FAIL menu_enter: state=%0d mi=%b tick=%b expected 2/0/0", state_dbg, menu_interrupt, move_tick);
        end
        for (int i = 1; i <= 15; i++) begin
            if (i == 7) difficulty_level = 2'd0;
            @(negedge clk);
            checks++;
            if (move_tick !== (i % 5 == 0)) begin
                failures++;
                $display("FAIL tick_spacing cycle %0d: tick=%b expected %b", i, move_tick, (i % 5 == 0));
            end
        end
    endtask

    task automatic test_pause();
        // Counter is 0 now; three more cycles bring it to 3
        for (int i = 0; i < 3; i++) @(negedge clk);
        send_key(8'h70);
        checks++;
        if (state_dbg !== 3'd3 || menu_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL pause_enter: state=%0d mi=%b expected 3/1", state_dbg, menu_interrupt);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (move_tick !== 1'b0 || state_dbg !== 3'd3) begin
                failures++;
                $display("FAIL pause_hold cycle %0d: tick=%b state=%0d expected 0/3", i, move_tick, state_dbg);
            end
        end
        send_key(8'h70);
        for (int i = 0; i <= 2; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (move_tick !== (i == 2) || state_dbg !== 3'd2) begin
                failures++;
                $display("FAIL pause_resume +%0d: tick=%b state=%0d expected %b/2", i, move_tick, state_dbg, (i == 2));
            end
        end
    endtask

    task automatic test_over_same_cycle();
        // Counter 0 -> 4 over four edges; the fifth edge would tick
        for (int i = 0; i < 4; i++) @(negedge clk);
        game_over = 1'b1;
        send_key(8'h70);
        checks++;
        if (state_dbg !== 3'd4 || move_tick !== 1'b0 || menu_interrupt !== 1'b0 || game_start !== 1'b1) begin
            failures++;
            $display("FAIL over_priority: state=%0d tick=%b mi=%b gs=%b expected 4/0/0/1",
                     state_dbg, move_tick, menu_interrupt, game_start);
        end
    endtask

    task automatic test_restart();
        send_key(8'h72);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (game_restart !== 1'b1 || state_dbg !== 3'd5) begin
                failures++;
                $display("FAIL restart_hold %0d: gr=%b state=%0d expected 1/5", i, game_restart, state_dbg);
            end
        end
        game_over = 1'b0;
        @(negedge clk);
        checks++;
        if (game_restart !== 1'b0 || state_dbg !== 3'd2) begin
            failures++;
            $display("FAIL restart_exit: gr=%b state=%0d expected 0/2", game_restart, state_dbg);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (move_tick !== (i == 5)) begin
                failures++;
                $display("FAIL restart_first_tick +%0d: tick=%b expected %b", i, move_tick, (i == 5));
            end
        end
    endtask

    task automatic test_back_to_back();
        key = 8'h70;
        key_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd3) begin
            failures++;
            $display("FAIL held_p_first: state=%0d expected 3", state_dbg);
        end
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (state_dbg !== 3'd2) begin
            failures++;
            $display("FAIL held_p_second: state=%0d expected 2", state_dbg);
        end
        send_key(8'h78);
        checks++;
        if (state_dbg !== 3'd2) begin
            failures++;
            $display("FAIL ignored_key: state=%0d expected 2", state_dbg);
        end
        send_key(8'h6D);
        checks++;
        if (state_dbg !== 3'd1 || menu_interrupt !== 1'b1) begin
            failures++;
            $display("FAIL play_to_menu: state=%0d mi=%b expected 1/1", state_dbg, menu_interrupt);
        end
        difficulty_level = 2'd3;
        send_key(8'h0D);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (move_tick !== (i % 4 == 0)) begin
                failures++;
                $display("FAIL diff3_spacing +%0d: tick=%b expected %b", i, move_tick, (i % 4 == 0));
            end
        end
        send_key(8'h70);
        send_key(8'h6D);
        checks++;
        if (state_dbg !== 3'd1) begin
            failures++;
            $display("FAIL pause_to_menu: state=%0d expected 1", state_dbg);
        end
    endtask

    task automatic test_rst_in_restart();
        send_key(8'h0D);
        game_over = 1'b1;
        @(negedge clk);
        send_key(8'h72);
        checks++;
        if (game_restart !== 1'b1) begin
            failures++;
            $display("FAIL reach_restart: gr=%b expected 1", game_restart);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (game_restart !== 1'b0 || game_start !== 1'b0 || state_dbg !== 3'd0 || menu_interrupt !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: gr=%b gs=%b state=%0d mi=%b expected 0/0/0/0",
                     game_restart, game_start, state_dbg, menu_interrupt);
        end
        game_over = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_intro_key();
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL intro_after_reset: state=%0d expected 0", state_dbg);
        end
        send_key(8'h41);
        checks++;
        if (state_dbg !== 3'd1 || game_start !== 1'b1) begin
            failures++;
            $display("FAIL intro_any_key: state=%0d gs=%b expected 1/1", state_dbg, game_start);
        end
    endtask

    task automatic test_illegal_state();
        force dut.state_q = 3'd7;
        @(posedge clk);
        #1;
        release dut.state_q;
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0 || game_start !== 1'b0) begin
            failures++;
            $display("FAIL illegal_recover: state=%0d gs=%b expected 0/0", state_dbg, game_start);
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL illegal_settle: state=%0d expected 0", state_dbg);
        end
    endtask

    initial begin
        rst = 1'b1;
        key = 8'h00;
        key_valid = 1'b0;
        game_over = 1'b0;
        difficulty_level = 2'd0;
        test_reset();
        test_play_ticks();
        test_pause();
        test_over_same_cycle();
        test_restart();
        test_back_to_back();
        test_rst_in_restart();
        test_intro_key();
        test_illegal_state();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_flow_sequencer.md
# game_flow_sequencer

Top-level game sequencer for the snake design: owns the intro → menu → play → game-over → restart flow and produces the snake move-rate tick. It consumes debounced UART key bytes and the `game_over` flag from `rect_controller`. It drives `game_start`, `menu_interrupt`, `game_restart` and a per-move strobe into the grid/rect datapath, so each display and control block no longer tracks game phase on its own.

## Interface
Parameters:
- `INTRO_CYCLES`, default 130_000_000: intro screen duration in clk cycles (2 s at 65 MHz).
- `DIV_0`, default 13_000_000: clk cycles per move tick, difficulty 0.
- `DIV_1`, default 8_125_000: clk cycles per move tick, difficulty 1.
- `DIV_2`, default 4_875_000: clk cycles per move tick, difficulty 2.
- `DIV_3`, default 3_250_000: clk cycles per move tick, difficulty 3.
- `DIV_x` must be ≥ 2. `INTRO_CYCLES` must be ≥ 1.

Ports:
- `clk` in 1: 65 MHz pixel clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `key` in 8: debounced received byte (ASCII).
- `key_valid` in 1: one-cycle strobe qualifying `key`.
- `game_over` in 1: level from `rect_controller`, collision detected.
- `difficulty_level` in 2: menu-selected difficulty.
- `game_start` out 1: level, 0 in INTRO, 1 in every other state.
- `menu_interrupt` out 1: level, 1 in MENU and PAUSE (freezes snake logic).
- `game_restart` out 1: high while in RESTART.
- `move_tick` out 1: one-cycle strobe, snake advances one cell.
- `state_dbg` out 3: encoded current state.

## Operation
- State encodings: INTRO=0, MENU=1, PLAY=2, PAUSE=3, OVER=4, RESTART=5. Codes 6 and 7 are illegal and recover to INTRO on the next clk.
- Key codes: ENTER=8'h0D, 'p'=8'h70, 'm'=8'h6D, 'r'=8'h72. Any other byte is ignored except in INTRO.
- INTRO:
  - Intro counter increments every cycle.
  - Go to MENU when the counter reaches `INTRO_CYCLES-1`, or on any `key_valid`, whichever occurs first.
- MENU:
  - `key_valid` with ENTER goes to PLAY.
  - On that transition, latch `difficulty_level` into `div_sel` and clear the tick counter.
- PLAY:
  - Tick counter (32 bit) counts 0..DIV-1, where DIV = DIV_[div_sel].
  - When the counter equals DIV-1: pulse `move_tick` and wrap the counter to 0.
  - Transition priority, highest first:
    - `game_over`=1 → OVER. Overrides a same-cycle key and suppresses a same-cycle tick.
    - 'p' → PAUSE.
    - 'm' → MENU.
- PAUSE:
  - Tick counter holds its value.
  - 'p' → PLAY. Counting resumes from the held value.
  - 'm' → MENU.
- OVER:
  - No ticks.
  - 'r' → RESTART.
  - ENTER → MENU.
- RESTART:
  - `game_restart`=1.
  - Stay in RESTART while `game_over`=1, for a minimum of one cycle.
  - On the first cycle with `game_over`=0, go to PLAY with the tick counter cleared. `div_sel` is unchanged.
- `difficulty_level` changes outside the MENU→PLAY transition have no effect until the next MENU→PLAY.

## Timing
- All outputs registered; none are combinational from inputs.
- Reset values (asynchronous): state INTRO, `game_start`=0, `menu_interrupt`=0, `game_restart`=0, `move_tick`=0, `state_dbg`=0, intro counter 0, tick counter 0, `div_sel`=0.
- Key-to-state latency: a `key_valid` sampled at edge N changes `state_dbg` and the level outputs after edge N, i.e. visible in cycle N+1.
- `game_over`-to-OVER latency: also 1 cycle.
- First `move_tick` after entering PLAY (from MENU or RESTART) occurs exactly DIV cycles after the state change. Subsequent ticks are spaced exactly DIV cycles apart.
- PAUSE inserts exactly the paused cycle count between ticks.
- `move_tick` is never high outside PLAY, and never high in two consecutive cycles.
- `game_restart` is asserted for at least 1 cycle and stays high while `game_over`=1. It deasserts in the same cycle that PLAY is entered.
- `key_valid` held high for multiple cycles acts on each cycle. Example: 'p' held two cycles gives PLAY→PAUSE→PLAY. Debouncing is upstream.
- Asserting `rst` at any point, including mid-RESTART or on a tick cycle, forces the reset values immediately, with no pulse glitch.

## Test plan
- Reset, no keys, `INTRO_CYCLES`=10 → `game_start` rises in cycle 10 after reset release, state MENU, `menu_interrupt`=1.
- MENU, `difficulty_level`=2, `DIV_2`=5, ENTER → PLAY; `move_tick` pulses at +5, +10, +15 cycles.
- Change `difficulty_level` to 0 mid-PLAY → spacing remains 5.
- PLAY with counter at 3 (`DIV`=5), 'p' → no ticks for 20 cycles.
- Then 'p' again → next tick exactly 2 cycles after re-entering PLAY.
- `game_over` and 'p' in the same cycle as a due tick → state OVER, no `move_tick`, `menu_interrupt`=0.
- OVER, 'r', with `game_over` held 3 more cycles → `game_restart` high 4 cycles, then PLAY with first tick DIV cycles later.
- Assert `rst` during RESTART → `game_restart`=0, `game_start`=0, `state_dbg`=0 in the same cycle.
- Force state to 7 → INTRO next cycle.
